seg7_scan_mux: RTL

//  Parametrised time-multiplexed driver for N common-anode 7-segment digits plus decimal points.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_mux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment display blocks.
// Segment patterns are gfedcba, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Anode pattern with only bit idx low; all ones when idx is outside the n digits.
  function automatic logic [7:0] onehot_low(input logic [2:0] idx, input int unsigned n);
    logic [7:0] v_pattern;
    v_pattern = '1;
    if (32'(idx) < n) v_pattern[idx] = 1'b0;
    return v_pattern;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment (gfedcba, active-low) lookup.
// Shared by every display block that shows hex digits.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for N common-anode 7-segment digits with decimal points,
// double-buffered data, leading-zero blanking, PWM brightness and a dead cycle per slot.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV_LOG2 = 16,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int SLOT_W = $clog2(N_DIGITS);
  localparam int PACK_W = 5 * N_DIGITS;

  logic [DIV_LOG2-1:0] r_cnt;
  logic [SLOT_W-1:0]   r_slot;
  logic [PACK_W-1:0]   r_pending;
  logic [PACK_W-1:0]   r_active;
  logic [N_DIGITS-1:0] r_an;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic                r_frame_tick;

  logic                  w_cnt_max;
  logic                  w_last_slot;
  logic                  w_wrap;
  logic [4*N_DIGITS-1:0] w_active_data;
  logic [N_DIGITS-1:0]   w_active_dp;
  logic [N_DIGITS-1:0]   w_lzblank;
  logic [3:0]            w_nibble;
  logic                  w_dp_sel;
  logic                  w_en_sel;
  logic                  w_lz_sel;
  logic                  w_pwm_on;
  logic                  w_lit;
  logic [6:0]            w_hex_seg;

  assign w_cnt_max     = &r_cnt;
  assign w_last_slot   = (r_slot == SLOT_W'(N_DIGITS - 1));
  assign w_wrap        = w_cnt_max & w_last_slot;
  assign w_active_data = r_active[4*N_DIGITS-1:0];
  assign w_active_dp   = r_active[PACK_W-1 -: N_DIGITS];

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    logic v_zero_above;
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    v_zero_above = 1'b1;
    w_lzblank    = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      v_zero_above = v_zero_above & (w_active_data[4*i +: 4] == 4'h0);
      w_lzblank[i] = lz_blank & v_zero_above;
    end
  end

  always_comb begin
    w_nibble = '0;
    w_dp_sel = 1'b0;
    w_en_sel = 1'b0;
    w_lz_sel = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_slot == SLOT_W'(i)) begin
        w_nibble = w_active_data[4*i +: 4];
        w_dp_sel = w_active_dp[i];
        w_en_sel = digit_en[i];
        w_lz_sel = w_lzblank[i];
      end
    end
  end

  // cnt == 0 is the dead cycle that keeps every anode off while the slot changes.
  assign w_pwm_on = (r_cnt[DIV_LOG2-1 -: BRIGHT_W] <= brightness);
  assign w_lit    = w_en_sel & ~w_lz_sel & w_pwm_on & (r_cnt != '0);

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_hex_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the display buffers are cleared too, so the scan restarts on a zero display after reset.
      r_cnt        <= '0;
      r_slot       <= '0;
      r_pending    <= '0;
      r_active     <= '0;
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge state.
      r_cnt <= r_cnt + 1'b1;
      if (w_cnt_max) r_slot <= w_last_slot ? '0 : r_slot + 1'b1;
      r_frame_tick <= w_wrap;
      if (load) r_pending <= {dp_in, data};
      // A load on the wrap cycle bypasses the pending buffer.
      if (w_wrap) r_active <= load ? {dp_in, data} : r_pending;
      r_an  <= w_lit ? N_DIGITS'(onehot_low(3'(r_slot), N_DIGITS)) : '1;
      r_seg <= w_lit ? w_hex_seg : SEG_BLANK;
      r_dp  <= w_lit ? ~w_dp_sel : 1'b1;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
